mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single SoC memory port between the core's instruction-fetch
//  master (m0) and load/store master (m1). Serialises transactions with one
//  outstanding at a time, arbitrates with LSU priority plus fetch
//  anti-starvation, and returns error responses on slave timeout. Sits
//  between the core and the RAM/MMIO decoder inside soc.
// PARAMETERS
//  AW         32  address width
//  DW         32  data width (strobe width DW/8)
//  STARVE_MAX 4   consecutive m0 losses before m0 is forced to win (>=1)
//  TIMEOUT    16  cycles in WAIT without s_rvalid before error (>=2)
// PORTS
//  clk        in   1     system clock, all logic on rising edge
//  rst        in   1     asynchronous, active-high reset
//  mX_req     in   1     (X=0,1) request valid; held until mX_ready
//  mX_we      in   1     1=write, 0=read
//  mX_addr    in   AW    byte address
//  mX_wdata   in   DW    write data
//  mX_wstrb   in   DW/8  byte write strobes
//  mX_ready   out  1     request accepted this cycle
//  mX_rvalid  out  1     response valid (read data or write ack), 1 cycle
//  mX_rdata   out  DW    read data, valid with mX_rvalid
//  mX_err     out  1     timeout error, valid with mX_rvalid
//  s_req      out  1     one-cycle command strobe to memory
//  s_we/s_addr/s_wdata/s_wstrb  out  as master  registered command fields
//  s_rvalid   in   1     memory response (reads and writes), any latency >=1
//  s_rdata    in   DW    memory read data
// BEHAVIOUR
//  Reset: state=IDLE, owner=0, starve_cnt=0, tmo_cnt=0; s_req=0, s_* fields
//   0; all mX_ready/mX_rvalid/mX_err=0, mX_rdata=0.
//  FSM IDLE -> ISSUE -> WAIT -> IDLE.
//  IDLE: if any mX_req, pick winner, assert its mX_ready combinationally this
//   cycle, latch its we/addr/wdata/wstrb into s_* regs and owner; -> ISSUE.
//   No req: stay IDLE.
//  Arbitration: only m1 req -> m1; only m0 -> m0; both -> m1 unless
//   starve_cnt==STARVE_MAX, then m0. starve_cnt increments (saturating) when
//   m0 req is high and m1 wins; clears whenever m0 wins.
//  ISSUE: s_req=1 for exactly this cycle; tmo_cnt cleared; -> WAIT.
//   s_rvalid in ISSUE is ignored (memory latency >=1 after s_req).
//  WAIT: s_req=0; tmo_cnt increments each cycle. On s_rvalid: owner's
//   mX_rvalid=1, mX_rdata=s_rdata, mX_err=0 (combinational, same cycle);
//   -> IDLE. If tmo_cnt==TIMEOUT-1 and no s_rvalid: owner's mX_rvalid=1,
//   mX_err=1, mX_rdata=0; -> IDLE. s_rvalid and timeout same cycle: normal
//   response wins, err=0.
//  Non-owner mX_rvalid/mX_err always 0; mX_rdata=0 when mX_rvalid=0.
//  s_rvalid in IDLE (late response after timeout) is dropped, no output.
//  Latency: request accepted in cycle N, s_req in N+1, response with
//   s_rvalid; minimum issue interval 2+memlat cycles; next arbitration in
//   the cycle after return to IDLE.
//  s_* fields hold their value until next acceptance (no glitching).
//  Reset mid-transaction: immediate return to reset values; outstanding
//   transaction abandoned, no response issued to any master.
// TESTING
//  1 Single m0 read addr 0x100, memory returns 0xDEADBEEF after 1 cycle ->
//    m0_ready cyc N, s_req cyc N+1, m0_rvalid=1 rdata=0xDEADBEEF cyc N+2.
//  2 m1 write addr 0x8000_0000 data 0x55 wstrb 4'b0001 -> s_we=1, fields
//    match, m1_rvalid=1 m1_err=0 on s_rvalid; m0 idle outputs stay 0.
//  3 m0 and m1 requesting continuously -> order m1 x4, m0, m1 x4, m0...
//    (STARVE_MAX=4); starve_cnt clears after each m0 grant.
//  4 Memory never answers m0 read -> m0_rvalid=1, m0_err=1, rdata=0 exactly
//    TIMEOUT cycles after ISSUE; later stray s_rvalid produces no output.
//  5 s_rvalid coincides with timeout cycle, s_rdata=0x1234 -> rvalid=1,
//    err=0, rdata=0x1234.
//  6 rst pulsed during WAIT of m1 read -> all outputs 0 asynchronously;
//    post-reset s_rvalid ignored; new m0 req served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master memory port arbiter: one transaction outstanding at a time,
// load/store priority with fetch anti-starvation, and timeout error responses.
module mem_arbiter #(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32,
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [AW-1:0]     m0_addr,
   input  logic [DW-1:0]     m0_wdata,
   input  logic [DW/8-1:0]   m0_wstrb,
   output logic              m0_ready,
   output logic              m0_rvalid,
   output logic [DW-1:0]     m0_rdata,
   output logic              m0_err,

   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [AW-1:0]     m1_addr,
   input  logic [DW-1:0]     m1_wdata,
   input  logic [DW/8-1:0]   m1_wstrb,
   output logic              m1_ready,
   output logic              m1_rvalid,
   output logic [DW-1:0]     m1_rdata,
   output logic              m1_err,

   output logic              s_req,
   output logic              s_we,
   output logic [AW-1:0]     s_addr,
   output logic [DW-1:0]     s_wdata,
   output logic [DW/8-1:0]   s_wstrb,
   input  logic              s_rvalid,
   input  logic [DW-1:0]     s_rdata
);

   localparam int unsigned SW = $clog2(STARVE_MAX + 1);
   localparam int unsigned TW = $clog2(TIMEOUT);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t          state;
   logic            owner;
   logic [SW-1:0]   starve_cnt;
   logic [TW-1:0]   tmo_cnt;

   logic            grant_m1_c;
   logic            accept_c;
   logic            tmo_hit_c;
   logic            resp_c;

   // Arbitration and response steering; a real response beats a same-cycle timeout.
   always_comb begin
      grant_m1_c = m1_req && !(m0_req && (starve_cnt == STARVE_LIM));
      accept_c   = (state == IDLE) && (m0_req || m1_req);
      tmo_hit_c  = (state == WAIT) && (tmo_cnt == TMO_LAST);
      resp_c     = (state == WAIT) && (s_rvalid || tmo_hit_c);

      m0_ready   = accept_c && !grant_m1_c;
      m1_ready   = accept_c && grant_m1_c;
      m0_rvalid  = resp_c && !owner;
      m1_rvalid  = resp_c && owner;
      m0_err     = m0_rvalid && !s_rvalid;
      m1_err     = m1_rvalid && !s_rvalid;
      m0_rdata   = (m0_rvalid && s_rvalid) ? s_rdata : '0;
      m1_rdata   = (m1_rvalid && s_rvalid) ? s_rdata : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= 1'b0;
         starve_cnt <= '0;
         tmo_cnt    <= '0;
         s_req      <= 1'b0;
         s_we       <= 1'b0;
         s_addr     <= '0;
         s_wdata    <= '0;
         s_wstrb    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept_c) begin
                  state   <= ISSUE;
                  owner   <= grant_m1_c;
                  s_req   <= 1'b1;
                  s_we    <= grant_m1_c ? m1_we    : m0_we;
                  s_addr  <= grant_m1_c ? m1_addr  : m0_addr;
                  s_wdata <= grant_m1_c ? m1_wdata : m0_wdata;
                  s_wstrb <= grant_m1_c ? m1_wstrb : m0_wstrb;
                  // Count consecutive contested losses of the fetch master.
                  if (!grant_m1_c)
                     starve_cnt <= '0;
                  else if (m0_req && (starve_cnt != STARVE_LIM))
                     starve_cnt <= starve_cnt + SW'(1);
               end
            end
            ISSUE: begin
               s_req   <= 1'b0;
               tmo_cnt <= '0;
               state   <= WAIT;
            end
            WAIT: begin
               tmo_cnt <= tmo_cnt + TW'(1);
               if (resp_c)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed transaction table, multi-cycle
// corner sequences, and randomized traffic against a transaction-level model.
module tb_mem_arbiter;

   localparam int unsigned AW   = 32;
   localparam int unsigned DW   = 32;
   localparam int unsigned SB   = DW / 8;
   localparam int unsigned SMAX = 4;
   localparam int unsigned TMO  = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_req, m0_we, m0_ready, m0_rvalid, m0_err;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata, m0_rdata;
   logic [SB-1:0] m0_wstrb;
   logic          m1_req, m1_we, m1_ready, m1_rvalid, m1_err;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata, m1_rdata;
   logic [SB-1:0] m1_wstrb;
   logic          s_req, s_we, s_rvalid;
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_wdata, s_rdata;
   logic [SB-1:0] s_wstrb;

   int checks   = 0;
   int failures = 0;

   mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rvalid(m0_rvalid),
      .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rvalid(m1_rvalid),
      .m1_rdata(m1_rdata), .m1_err(m1_err),
      .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_wstrb(s_wstrb), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            m;
      logic          we;
      logic [31:0]   addr;
      logic [31:0]   wdata;
      logic [3:0]    wstrb;
      int            lat;        // s_rvalid this many cycles after s_req; 0 = never
      logic [31:0]   mem_rdata;
      int            exp_cyc;    // response expected this many cycles after s_req
      logic          exp_err;
      logic [31:0]   exp_rdata;
   } vec_t;

   vec_t vecs [7];

   task automatic chk_b(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Owner's response must match; the other master must stay silent.
   task automatic chk_resp(input string tag, input int own, input logic rv,
                           input logic er, input logic [31:0] rd);
      logic a_rv, a_er, o_rv, o_er;
      logic [31:0] a_rd, o_rd;
      if (own == 1) begin
         a_rv = m1_rvalid; a_er = m1_err; a_rd = m1_rdata;
         o_rv = m0_rvalid; o_er = m0_err; o_rd = m0_rdata;
      end else begin
         a_rv = m0_rvalid; a_er = m0_err; a_rd = m0_rdata;
         o_rv = m1_rvalid; o_er = m1_err; o_rd = m1_rdata;
      end
      chk_b({tag, "_rvalid"}, a_rv, rv);
      chk_b({tag, "_err"}, a_er, er);
      chk_w({tag, "_rdata"}, a_rd, rd);
      chk_b({tag, "_other_rvalid"}, o_rv, 1'b0);
      chk_b({tag, "_other_err"}, o_er, 1'b0);
      chk_w({tag, "_other_rdata"}, o_rd, 32'h0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk_b({tag, "_m0_ready"}, m0_ready, 1'b0);
      chk_b({tag, "_m1_ready"}, m1_ready, 1'b0);
      chk_resp(tag, 0, 1'b0, 1'b0, 32'h0);
      chk_b({tag, "_s_req"}, s_req, 1'b0);
      chk_b({tag, "_s_we"}, s_we, 1'b0);
      chk_w({tag, "_s_addr"}, s_addr, 32'h0);
      chk_w({tag, "_s_wdata"}, s_wdata, 32'h0);
      chk_w({tag, "_s_wstrb"}, 32'(s_wstrb), 32'h0);
   endtask

   task automatic drive_m(input int m, input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb);
      if (m == 1) begin
         m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb;
      end else begin
         m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb;
      end
   endtask

   task automatic idle_inputs();
      drive_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      s_rvalid = 1'b0;
      s_rdata  = 32'h0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // One isolated transaction: accept, issue, then wait for the expected response.
   task automatic do_txn(input vec_t v, input string tag);
      bit got;
      @(posedge clk); #1;
      drive_m(v.m, 1'b1, v.we, v.addr, v.wdata, v.wstrb);
      drive_m(1 - v.m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      s_rvalid = 1'b0;
      @(negedge clk);
      chk_b({tag, "_ready"}, v.m == 1 ? m1_ready : m0_ready, 1'b1);
      chk_b({tag, "_other_ready"}, v.m == 1 ? m0_ready : m1_ready, 1'b0);
      @(posedge clk); #1;
      drive_m(v.m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      chk_b({tag, "_s_req"}, s_req, 1'b1);
      chk_b({tag, "_s_we"}, s_we, v.we);
      chk_w({tag, "_s_addr"}, s_addr, v.addr);
      chk_w({tag, "_s_wdata"}, s_wdata, v.wdata);
      chk_w({tag, "_s_wstrb"}, 32'(s_wstrb), 32'(v.wstrb));
      chk_resp({tag, "_issue"}, v.m, 1'b0, 1'b0, 32'h0);
      got = 1'b0;
      for (int k = 1; k <= int'(TMO) + 2 && !got; k++) begin
         @(posedge clk); #1;
         s_rvalid = (k == v.lat);
         s_rdata  = (k == v.lat) ? v.mem_rdata : $urandom;
         @(negedge clk);
         if (k == v.exp_cyc) begin
            chk_resp({tag, "_resp"}, v.m, 1'b1, v.exp_err, v.exp_rdata);
            got = 1'b1;
         end else begin
            chk_resp({tag, "_wait"}, v.m, 1'b0, 1'b0, 32'h0);
         end
      end
      @(posedge clk); #1;
      s_rvalid = 1'b0;
   endtask

   // Randomized-traffic model state
   bit            pend [2];
   logic          p_we [2];
   logic [31:0]   p_addr [2];
   logic [31:0]   p_wdata [2];
   logic [3:0]    p_wstrb [2];
   int            ph, k, lat, own, losses, win;
   logic          e_we;
   logic [31:0]   e_addr, e_wdata;
   logic [3:0]    e_wstrb;
   int            grants [$];
   int            exp_order [10];

   initial begin
      rst = 1'b1;
      idle_inputs();

      vecs[0] = '{0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 1, 32'hDEAD_BEEF, 1, 1'b0, 32'hDEAD_BEEF};
      vecs[1] = '{1, 1'b1, 32'h8000_0000, 32'h55, 4'b0001, 3, 32'h0, 3, 1'b0, 32'h0};
      vecs[2] = '{0, 1'b0, 32'h0000_0200, 32'h0, 4'h0, 0, 32'h0, int'(TMO), 1'b1, 32'h0};
      vecs[3] = '{1, 1'b0, 32'h0000_0300, 32'h0, 4'h0, int'(TMO), 32'h1234, int'(TMO), 1'b0, 32'h1234};
      vecs[4] = '{1, 1'b0, 32'h0000_0400, 32'h0, 4'h0, int'(TMO) - 1, 32'hA5A5_0001, int'(TMO) - 1, 1'b0, 32'hA5A5_0001};
      vecs[5] = '{0, 1'b1, 32'h1000_0008, 32'hCAFE_F00D, 4'b1100, 2, 32'hFFFF_FFFF, 2, 1'b0, 32'hFFFF_FFFF};
      vecs[6] = '{1, 1'b0, 32'h0000_0500, 32'h0, 4'h0, int'(TMO) + 1, 32'h7777, int'(TMO), 1'b1, 32'h0};
      exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

      #2 chk_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 7; i++)
         do_txn(vecs[i], $sformatf("vec%0d", i));

      // Late response arriving while idle must be dropped
      @(posedge clk); #1;
      s_rvalid = 1'b1; s_rdata = 32'h0BAD_0BAD;
      @(negedge clk);
      chk_resp("stray", 0, 1'b0, 1'b0, 32'h0);
      chk_b("stray_s_req", s_req, 1'b0);
      @(posedge clk); #1 s_rvalid = 1'b0;

      // Both masters requesting continuously; memory answers every first WAIT cycle
      do_reset();
      @(posedge clk); #1;
      drive_m(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
      drive_m(1, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'h0);
      s_rvalid = 1'b1; s_rdata = 32'h0000_00AA;
      for (int c = 0; c < 80 && grants.size() < 10; c++) begin
         @(negedge clk);
         if (m1_ready) grants.push_back(1);
         else if (m0_ready) grants.push_back(0);
         @(posedge clk); #1;
      end
      idle_inputs();
      for (int i = 0; i < 10; i++)
         chk_w($sformatf("starve_grant%0d", i),
               32'(i < grants.size() ? grants[i] : 2), 32'(exp_order[i]));
      repeat (4) @(posedge clk);

      // Asynchronous reset during an m1 read wait
      do_reset();
      @(posedge clk); #1;
      drive_m(1, 1'b1, 1'b0, 32'h0000_0600, 32'h0, 4'hF);
      @(negedge clk);
      chk_b("rst_m1_ready", m1_ready, 1'b1);
      @(posedge clk); #1;
      drive_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1 rst = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h5555_AAAA;
      #1 chk_all_zero("async_rst");
      @(posedge clk); #1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk_resp("post_rst_stray", 1, 1'b0, 1'b0, 32'h0);
      @(posedge clk); #1 s_rvalid = 1'b0;
      do_txn(vecs[0], "post_rst");

      // Randomized traffic against a transaction-level model
      do_reset();
      ph = 0; k = 0; lat = 0; own = 0; losses = 0; win = 0;
      e_we = 1'b0; e_addr = 32'h0; e_wdata = 32'h0; e_wstrb = 4'h0;
      for (int m = 0; m < 2; m++) begin
         pend[m] = 1'b0; p_we[m] = 1'b0; p_addr[m] = 32'h0; p_wdata[m] = 32'h0; p_wstrb[m] = 4'h0;
      end
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk); #1;
         for (int m = 0; m < 2; m++)
            drive_m(m, pend[m], p_we[m], p_addr[m], p_wdata[m], p_wstrb[m]);
         s_rdata  = $urandom;
         s_rvalid = (ph == 2) ? (k == lat) : ($urandom_range(0, 3) == 0);
         @(negedge clk);

         if (ph == 0 && (pend[0] || pend[1])) begin
            // Fetch wins a contested round only after SMAX consecutive losses
            win = (pend[1] && !(pend[0] && losses >= int'(SMAX))) ? 1 : 0;
            chk_b("rnd_m0_ready", m0_ready, win == 0);
            chk_b("rnd_m1_ready", m1_ready, win == 1);
         end else begin
            chk_b("rnd_m0_ready_idle", m0_ready, 1'b0);
            chk_b("rnd_m1_ready_idle", m1_ready, 1'b0);
         end
         if (ph == 2)
            chk_resp("rnd", own, (k == lat) || (k == int'(TMO)),
                     (k == int'(TMO)) && (k != lat), (k == lat) ? s_rdata : 32'h0);
         else
            chk_resp("rnd_quiet", 0, 1'b0, 1'b0, 32'h0);
         chk_b("rnd_s_req", s_req, ph == 1);
         chk_b("rnd_s_we", s_we, e_we);
         chk_w("rnd_s_addr", s_addr, e_addr);
         chk_w("rnd_s_wdata", s_wdata, e_wdata);
         chk_w("rnd_s_wstrb", 32'(s_wstrb), 32'(e_wstrb));

         if (ph == 0 && (pend[0] || pend[1])) begin
            own = win;
            if (win == 0) losses = 0;
            else if (pend[0]) losses++;
            e_we = p_we[win]; e_addr = p_addr[win]; e_wdata = p_wdata[win]; e_wstrb = p_wstrb[win];
            pend[win] = 1'b0;
            case ($urandom_range(0, 9))
               0: lat = 0;
               1: lat = int'(TMO);
               2: lat = int'(TMO) + 1;
               3: lat = int'(TMO) - 1;
               default: lat = int'($urandom_range(1, 4));
            endcase
            ph = 1;
         end else if (ph == 1) begin
            ph = 2; k = 1;
         end else if (ph == 2) begin
            if (k == lat || k == int'(TMO)) ph = 0;
            else k++;
         end
         for (int m = 0; m < 2; m++) begin
            if (!pend[m] && $urandom_range(0, 2) == 0) begin
               pend[m] = 1'b1; p_we[m] = 1'($urandom_range(0, 1));
               p_addr[m] = $urandom; p_wdata[m] = $urandom; p_wstrb[m] = 4'($urandom);
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
